// File: rtl/req_encoder16_if.sv
// Request/grant bus for req_encoder16: request lines in, registered index plus
// pending vector out, with a valid/ack handshake on the index.
interface req_encoder16_if;
  logic [15:0] req;
  logic        ack;
  logic [3:0]  code;
  logic        valid;
  logic [15:0] pending;

  // Producer of requests and consumer of codes.
  modport master (
    output req,
    output ack,
    input  code,
    input  valid,
    input  pending
  );

  // The encoder itself.
  modport slave (
    input  req,
    input  ack,
    output code,
    output valid,
    output pending
  );
endinterface

// File: rtl/req_encoder16.sv
// Sixteen-line request-to-index encoder. Request lines set sticky pending bits;
// a round-robin arbiter picks one pending line at a time and presents its index
// on a valid/ack handshake. All outputs are registered.
module req_encoder16 #(
  parameter int unsigned UUID = 0,
  parameter string       NAME = ""
) (
  input logic            clk,
  input logic            rst,
  req_encoder16_if.slave bus_io
);

  // Identification parameters carry no function.
  if (UUID == 32'hFFFF_FFFF && NAME == "") begin : g_id_unused
  end

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e      state_q;
  logic [15:0] pend_q;
  logic [15:0] pend_d;
  logic [15:0] served;
  logic [3:0]  ptr_q;
  logic [3:0]  code_q;
  logic        valid_q;
  logic [3:0]  pick;
  logic        pick_found;
  logic [3:0]  scan_idx;

  // Pending update: clear the line being accepted, but a same-cycle request wins.
  always_comb begin
    served = '0;
    if (valid_q && bus_io.ack) begin
      served = 16'b1 << code_q;
    end
    pend_d = (pend_q & ~served) | bus_io.req;
  end

  // Round-robin search of the registered pending vector starting at ptr_q.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    scan_idx   = '0;
    for (int k = 0; k < 16; k++) begin
      scan_idx = ptr_q + 4'(k);
      if (!pick_found && pend_q[scan_idx]) begin
        pick       = scan_idx;
        pick_found = 1'b1;
      end
    end
  end

  // Grant FSM with registered code/valid; pending vector captured every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= '0;
      ptr_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            code_q  <= pick;
            valid_q <= 1'b1;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (bus_io.ack) begin
            valid_q <= 1'b0;
            ptr_q   <= code_q + 4'd1;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign bus_io.code    = code_q;
  assign bus_io.valid   = valid_q;
  assign bus_io.pending = pend_q;

endmodule

// File: tb/tb_req_encoder16.sv
// Bench for req_encoder16: directed scenarios then random traffic, checked by a
// reference model that feeds an expected-grant queue drained by a monitor.
module tb_req_encoder16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  req_encoder16_if bus();

  req_encoder16 #(
    .UUID(7),
    .NAME("enc0")
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  // Reference model state: pending flags, round-robin start, grant in flight.
  bit m_pend[16];
  int m_ptr  = 0;
  bit m_busy = 1'b0;
  int m_code = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] model_pend_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 16; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Reference model, advanced on each clock edge or reset assertion.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
        m_ptr  = 0;
        m_busy = 1'b0;
        m_code = 0;
        exp_q.delete();
      end else begin
        bit nxt[16];
        int served;
        served = (m_busy && bus.ack) ? m_code : -1;
        for (int i = 0; i < 16; i++) nxt[i] = (m_pend[i] && i != served) || bus.req[i];
        if (m_busy) begin
          if (bus.ack) begin
            m_busy = 1'b0;
            m_ptr  = (m_code + 1) % 16;
          end
        end else begin
          for (int k = 0; k < 16; k++) begin
            int j;
            j = (m_ptr + k) % 16;
            if (m_pend[j]) begin
              m_code = j;
              m_busy = 1'b1;
              exp_q.push_back(j);
              break;
            end
          end
        end
        for (int i = 0; i < 16; i++) m_pend[i] = nxt[i];
      end
    end
  end

  // Monitor: compares on the falling edge, pops an expected code per new grant.
  initial begin
    int prev_v;
    int hold;
    prev_v = 0;
    hold   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 0;
        hold   = 0;
      end else begin
        chk("valid", 32'(bus.valid), 32'(m_busy));
        chk("pending", 32'(bus.pending), model_pend_vec());
        if (bus.valid && prev_v == 0) begin
          if (exp_q.size() == 0) chk("grant_unexpected", 32'(bus.valid), 32'd0);
          else hold = exp_q.pop_front();
        end
        chk("code", 32'(bus.code), 32'(hold));
        prev_v = int'(bus.valid);
      end
    end
  end

  // One cycle of stimulus, applied just after the rising edge.
  task automatic drive(input logic [15:0] r, input logic a);
    bus.req = r;
    bus.ack = a;
    @(posedge clk);
    #1;
  endtask

  // Consumer that accepts every grant immediately.
  task automatic auto_ack(input logic [15:0] r, input int n);
    repeat (n) drive(r, bus.valid);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    logic        a;
    int          guard;
    bus.req = '0;
    bus.ack = 1'b0;

    #2;
    chk("reset_valid", 32'(bus.valid), 32'd0);
    chk("reset_code", 32'(bus.code), 32'd0);
    chk("reset_pending", 32'(bus.pending), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request: 2-cycle latency, held through stall, cleared on ack.
    drive(16'h0020, 1'b0);
    chk("single_pend", 32'(bus.pending), 32'h20);
    chk("single_no_valid_yet", 32'(bus.valid), 32'd0);
    drive(16'h0000, 1'b0);
    chk("single_valid", 32'(bus.valid), 32'd1);
    chk("single_code", 32'(bus.code), 32'd5);
    drive(16'h0000, 1'b0);
    drive(16'h0000, 1'b0);
    drive(16'h0000, 1'b1);
    chk("single_ack_valid", 32'(bus.valid), 32'd0);
    chk("single_ack_pend", 32'(bus.pending), 32'd0);
    drive(16'h0000, 1'b0);

    // Wrap order from reset: 0 then 15.
    do_reset();
    drive(16'h8001, 1'b0);
    auto_ack(16'h0000, 8);

    // Fairness between two continuously requesting lines.
    auto_ack(16'h0088, 12);
    auto_ack(16'h0000, 6);

    // Stall with code 2 while bit 0 arrives; next grant wraps to 0.
    drive(16'h0004, 1'b0);
    drive(16'h0000, 1'b0);
    drive(16'h0000, 1'b0);
    drive(16'h0001, 1'b0);
    drive(16'h0000, 1'b0);
    drive(16'h0000, 1'b0);
    chk("stall_code", 32'(bus.code), 32'd2);
    chk("stall_pend", 32'(bus.pending), 32'h5);
    drive(16'h0000, 1'b1);
    auto_ack(16'h0000, 6);

    // Spurious ack while idle.
    drive(16'h0000, 1'b1);
    drive(16'h0000, 1'b1);
    drive(16'h0000, 1'b1);

    // Asynchronous reset while holding code 9 with pending 0x0300.
    drive(16'h0200, 1'b0);
    drive(16'h0000, 1'b0);
    drive(16'h0100, 1'b0);
    drive(16'h0000, 1'b0);
    chk("hold_code9", 32'(bus.code), 32'd9);
    chk("hold_pend", 32'(bus.pending), 32'h300);
    #2;
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(bus.valid), 32'd0);
    chk("async_code", 32'(bus.code), 32'd0);
    chk("async_pending", 32'(bus.pending), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(16'h0000, 1'b0);
    drive(16'h0000, 1'b0);
    drive(16'h0000, 1'b0);

    // Random traffic with a consumer that sometimes stalls.
    repeat (1500) begin
      r = ($urandom_range(0, 3) == 0) ? 16'($urandom & $urandom) : 16'h0000;
      a = bus.valid ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      drive(r, a);
    end

    // Drain remaining requests within a bounded number of cycles.
    guard = 0;
    while ((m_busy || model_pend_vec() != 0 || bus.valid) && guard < 300) begin
      drive(16'h0000, bus.valid);
      guard++;
    end
    chk("drain_in_time", 32'(guard < 300), 32'd1);
    @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
